// File: rtl/spad_accum.sv
// PE scratchpad: 1R1W memory with registered read handshake, two-stage signed
// accumulate-in-place writes, a hardware zero-fill sweep and a sticky overflow flag.
module spad_accum #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 9,
    parameter bit SATURATE      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_req,
    input  logic [ADDR_BITWIDTH-1:0] r_addr,
    output logic [DATA_BITWIDTH-1:0] r_data,
    output logic                     r_valid,
    input  logic                     write_en,
    input  logic                     acc_en,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     acc_ovf
);

    localparam int DEPTH = 1 << ADDR_BITWIDTH;
    localparam logic [DATA_BITWIDTH-1:0] SMAX = {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
    localparam logic [DATA_BITWIDTH-1:0] SMIN = {1'b1, {(DATA_BITWIDTH-1){1'b0}}};
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = {ADDR_BITWIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Returns {overflow, result}; the sum is formed one bit wider so the sign
    // disagreement between the top two bits exposes signed overflow.
    function automatic logic [DATA_BITWIDTH:0] acc_add(
        input logic [DATA_BITWIDTH-1:0] operand,
        input logic [DATA_BITWIDTH-1:0] addend
    );
        logic [DATA_BITWIDTH:0]   sum;
        logic                     ovf;
        logic [DATA_BITWIDTH-1:0] res;
        sum = {operand[DATA_BITWIDTH-1], operand} + {addend[DATA_BITWIDTH-1], addend};
        ovf = sum[DATA_BITWIDTH] ^ sum[DATA_BITWIDTH-1];
        if (ovf && SATURATE) begin
            res = sum[DATA_BITWIDTH] ? SMIN : SMAX;
        end else begin
            res = sum[DATA_BITWIDTH-1:0];
        end
        return {ovf, res};
    endfunction

    logic [DATA_BITWIDTH-1:0] mem_r [DEPTH];

    state_t                   state_r;
    logic [ADDR_BITWIDTH-1:0] clr_addr_r;

    logic                     acc_vld_r;
    logic [ADDR_BITWIDTH-1:0] acc_addr_r;
    logic [DATA_BITWIDTH-1:0] acc_addend_r;
    logic [DATA_BITWIDTH-1:0] acc_operand_r;

    logic                     idle_s;
    logic                     clr_start_s;
    logic                     wr_accept_s;
    logic                     ovw_s;
    logic                     acc_start_s;
    logic [DATA_BITWIDTH:0]   acc_sum_s;
    logic                     acc_ovf_s;
    logic [DATA_BITWIDTH-1:0] acc_result_s;
    logic [DATA_BITWIDTH-1:0] rd_word_s;
    logic [DATA_BITWIDTH-1:0] op_word_s;

    // Request qualification: a clear request in IDLE takes priority over any write.
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        clr_start_s = idle_s && clear_req;
        wr_accept_s = idle_s && write_en && !clear_req;
        ovw_s       = wr_accept_s && !acc_en;
        acc_start_s = wr_accept_s && acc_en;
    end

    // Commit-stage arithmetic for the accumulate pipeline.
    always_comb begin
        acc_sum_s    = acc_add(acc_operand_r, acc_addend_r);
        acc_ovf_s    = acc_sum_s[DATA_BITWIDTH];
        acc_result_s = acc_sum_s[DATA_BITWIDTH-1:0];
    end

    // Word lookup with forwarding of the sum that is committing this cycle.
    always_comb begin
        if (acc_vld_r && (acc_addr_r == r_addr)) begin
            rd_word_s = acc_result_s;
        end else begin
            rd_word_s = mem_r[r_addr];
        end
        if (acc_vld_r && (acc_addr_r == w_addr)) begin
            op_word_s = acc_result_s;
        end else begin
            op_word_s = mem_r[w_addr];
        end
    end

    // Clear-sweep FSM with registered busy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            clr_addr_r <= {ADDR_BITWIDTH{1'b0}};
            busy       <= 1'b0;
            acc_ovf    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_start_s) begin
                        state_r    <= ST_CLEAR;
                        clr_addr_r <= {ADDR_BITWIDTH{1'b0}};
                        busy       <= 1'b1;
                        acc_ovf    <= 1'b0;
                    end else if (acc_vld_r && acc_ovf_s) begin
                        acc_ovf <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_addr_r <= clr_addr_r + ADDR_BITWIDTH'(1);
                    if (clr_addr_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Accumulate capture stage: address, addend and (forwarded) operand.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_vld_r     <= 1'b0;
            acc_addr_r    <= {ADDR_BITWIDTH{1'b0}};
            acc_addend_r  <= {DATA_BITWIDTH{1'b0}};
            acc_operand_r <= {DATA_BITWIDTH{1'b0}};
        end else begin
            acc_vld_r <= acc_start_s;
            if (acc_start_s) begin
                acc_addr_r    <= w_addr;
                acc_addend_r  <= w_data;
                acc_operand_r <= op_word_s;
            end
        end
    end

    // Storage array; a same-edge overwrite is newer than the committing sum, so it lands last.
    always_ff @(posedge clk) begin
        if (acc_vld_r) begin
            mem_r[acc_addr_r] <= acc_result_s;
        end
        if (state_r == ST_CLEAR) begin
            mem_r[clr_addr_r] <= {DATA_BITWIDTH{1'b0}};
        end else if (ovw_s) begin
            mem_r[w_addr] <= w_data;
        end
    end

    // Registered read port; r_data holds its last value between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= {DATA_BITWIDTH{1'b0}};
            r_valid <= 1'b0;
        end else if (read_req && idle_s) begin
            r_data  <= rd_word_s;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spad_accum.sv
// Self-checking bench for spad_accum: saturating and wrapping instances share
// stimulus and are compared against an integer-arithmetic memory model.
module tb_spad_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_req = 1'b0;
    logic [8:0]  r_addr = 9'd0;
    logic        write_en = 1'b0;
    logic        acc_en = 1'b0;
    logic [8:0]  w_addr = 9'd0;
    logic [15:0] w_data = 16'd0;
    logic        clear_req = 1'b0;

    logic [15:0] r_data_s, r_data_w;
    logic        r_valid_s, r_valid_w, busy_s, busy_w, acc_ovf_s, acc_ovf_w;

    int n_checks = 0;
    int n_fail = 0;

    // model state: memory seen by a reader, expected read outputs, overflow flags
    logic [15:0] ms [512];
    logic [15:0] mw [512];
    bit          exp_rvalid = 1'b0;
    logic [15:0] exp_rdata_s = 16'd0;
    logic [15:0] exp_rdata_w = 16'd0;
    bit          ovf_s = 1'b0, ovf_w = 1'b0, pend_s = 1'b0, pend_w = 1'b0;
    int          busy_cnt = 0;

    spad_accum #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(9), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .read_req(read_req), .r_addr(r_addr),
        .r_data(r_data_s), .r_valid(r_valid_s), .write_en(write_en), .acc_en(acc_en),
        .w_addr(w_addr), .w_data(w_data), .clear_req(clear_req), .busy(busy_s),
        .acc_ovf(acc_ovf_s)
    );

    spad_accum #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(9), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .read_req(read_req), .r_addr(r_addr),
        .r_data(r_data_w), .r_valid(r_valid_w), .write_en(write_en), .acc_en(acc_en),
        .w_addr(w_addr), .w_data(w_data), .clear_req(clear_req), .busy(busy_w),
        .acc_ovf(acc_ovf_w)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                              input bit sat, output bit ovf);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        ovf = (s > 32767) || (s < -32768);
        if (ovf && sat) s = (s > 0) ? 32767 : -32768;
        return s[15:0];
    endfunction

    // One clock: drive inputs, advance the model, then wait until just after the edge.
    task automatic step(input bit rd, input logic [8:0] ra, input bit we, input bit acc,
                        input logic [8:0] wa, input logic [15:0] wd, input bit clr);
        bit o;
        read_req = rd; r_addr = ra; write_en = we; acc_en = acc;
        w_addr = wa; w_data = wd; clear_req = clr;
        exp_rvalid = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
        end else begin
            ovf_s = ovf_s | pend_s; ovf_w = ovf_w | pend_w;
            pend_s = 1'b0; pend_w = 1'b0;
            if (rd) begin
                exp_rvalid = 1'b1; exp_rdata_s = ms[ra]; exp_rdata_w = mw[ra];
            end
            if (clr) begin
                busy_cnt = 512; ovf_s = 1'b0; ovf_w = 1'b0;
                for (int i = 0; i < 512; i++) begin ms[i] = 16'd0; mw[i] = 16'd0; end
            end else if (we && acc) begin
                ms[wa] = model_add(ms[wa], wd, 1'b1, o); pend_s = o;
                mw[wa] = model_add(mw[wa], wd, 1'b0, o); pend_w = o;
            end else if (we) begin
                ms[wa] = wd; mw[wa] = wd;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
    endtask

    task automatic model_reset();
        exp_rvalid = 1'b0; exp_rdata_s = 16'd0; exp_rdata_w = 16'd0;
        ovf_s = 1'b0; ovf_w = 1'b0; pend_s = 1'b0; pend_w = 1'b0; busy_cnt = 0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({r_valid_s, r_data_s, busy_s, acc_ovf_s} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_sat: valid=%0b data=%h busy=%0b ovf=%0b, required all 0",
                     r_valid_s, r_data_s, busy_s, acc_ovf_s);
        end
        n_checks++;
        if ({r_valid_w, r_data_w, busy_w, acc_ovf_w} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_wrap: valid=%0b data=%h busy=%0b ovf=%0b, required all 0",
                     r_valid_w, r_data_w, busy_w, acc_ovf_w);
        end
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_write_read();
        step(1'b0, 9'd0, 1'b1, 1'b0, 9'd5, 16'h1234, 1'b0);
        step(1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if ({r_valid_s, r_data_s} !== {1'b1, 16'h1234} || {r_valid_w, r_data_w} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL write_read: got %0b/%h %0b/%h, required 1/1234",
                     r_valid_s, r_data_s, r_valid_w, r_data_w);
        end
        idle();
        n_checks++;
        if (r_valid_s !== 1'b0 || r_data_s !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_hold: valid=%0b data=%h, required 0/1234", r_valid_s, r_data_s);
        end
    endtask

    task automatic test_accumulate();
        step(1'b0, 9'd0, 1'b1, 1'b0, 9'd500, 16'd10, 1'b0);
        step(1'b0, 9'd0, 1'b1, 1'b1, 9'd500, 16'd3, 1'b0);
        step(1'b0, 9'd0, 1'b1, 1'b1, 9'd500, 16'd4, 1'b0);
        step(1'b0, 9'd0, 1'b1, 1'b1, 9'd500, 16'd5, 1'b0);
        step(1'b1, 9'd500, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_valid_s !== 1'b1 || r_data_s !== 16'd22 || r_data_w !== 16'd22) begin
            n_fail++;
            $display("FAIL acc_chain: got %0b/%0d/%0d, required 1/22/22", r_valid_s, r_data_s, r_data_w);
        end
        n_checks++;
        if (acc_ovf_s !== 1'b0 || acc_ovf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL acc_chain_ovf: got %0b %0b, required 0 0", acc_ovf_s, acc_ovf_w);
        end
    endtask

    task automatic test_saturate();
        step(1'b0, 9'd0, 1'b1, 1'b0, 9'd7, 16'h7FF0, 1'b0);
        step(1'b0, 9'd0, 1'b1, 1'b1, 9'd7, 16'h0020, 1'b0);
        n_checks++;
        if (acc_ovf_s !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: got %0b before commit edge, required 0", acc_ovf_s);
        end
        step(1'b1, 9'd7, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_data_s !== 16'h7FFF || r_data_w !== 16'h8010) begin
            n_fail++;
            $display("FAIL sat_wrap: got %h %h, required 7fff 8010", r_data_s, r_data_w);
        end
        n_checks++;
        if (acc_ovf_s !== 1'b1 || acc_ovf_w !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %0b %0b, required 1 1", acc_ovf_s, acc_ovf_w);
        end
    endtask

    task automatic test_same_cycle();
        step(1'b0, 9'd0, 1'b1, 1'b0, 9'd9, 16'd1, 1'b0);
        step(1'b1, 9'd9, 1'b1, 1'b0, 9'd9, 16'd2, 1'b0);
        n_checks++;
        if (r_data_s !== 16'd1) begin
            n_fail++;
            $display("FAIL same_cycle_ovw: got %0d, required 1", r_data_s);
        end
        step(1'b1, 9'd9, 1'b1, 1'b1, 9'd9, 16'd5, 1'b0);
        n_checks++;
        if (r_data_s !== 16'd2) begin
            n_fail++;
            $display("FAIL same_cycle_acc: got %0d, required 2", r_data_s);
        end
        step(1'b1, 9'd9, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_data_s !== 16'd7 || r_data_w !== 16'd7) begin
            n_fail++;
            $display("FAIL acc_forward: got %0d %0d, required 7 7", r_data_s, r_data_w);
        end
    endtask

    task automatic test_clear();
        int n;
        int busy_reads;
        step(1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 16'hDEAD, 1'b1);
        n = 0;
        busy_reads = 0;
        for (int i = 0; i < 600 && busy_s === 1'b1; i++) begin
            n++;
            step(1'b1, 9'($urandom), 1'b1, 1'($urandom_range(0, 1)),
                 (i % 2 == 0) ? 9'd0 : 9'd255, 16'hBEEF, 1'($urandom_range(0, 1)));
            if (r_valid_s !== 1'b0) busy_reads++;
        end
        n_checks++;
        if (n !== 512) begin
            n_fail++;
            $display("FAIL busy_len: busy high %0d cycles, required 512", n);
        end
        n_checks++;
        if (busy_reads !== 0) begin
            n_fail++;
            $display("FAIL busy_read: %0d reads returned valid during sweep, required 0", busy_reads);
        end
        step(1'b1, 9'd0, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_valid_s !== 1'b1 || r_data_s !== 16'd0 || r_data_w !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_addr0: got %0b/%h/%h, required 1/0/0", r_valid_s, r_data_s, r_data_w);
        end
        step(1'b1, 9'd255, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_data_s !== 16'd0 || r_data_w !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_addr255: got %h %h, required 0 0", r_data_s, r_data_w);
        end
        step(1'b1, 9'd511, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_data_s !== 16'd0 || r_data_w !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_addr511: got %h %h, required 0 0", r_data_s, r_data_w);
        end
        n_checks++;
        if (acc_ovf_s !== 1'b0 || acc_ovf_w !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ovf: got %0b %0b, required 0 0", acc_ovf_s, acc_ovf_w);
        end
    endtask

    task automatic test_random();
        logic [15:0] wd;
        for (int i = 0; i < 400; i++) begin
            wd = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 9'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 9'($urandom_range(0, 7)), wd, 1'b0);
            n_checks++;
            if (r_valid_s !== exp_rvalid || r_data_s !== exp_rdata_s) begin
                n_fail++;
                $display("FAIL rand_sat[%0d]: got %0b/%h, required %0b/%h",
                         i, r_valid_s, r_data_s, exp_rvalid, exp_rdata_s);
            end
            n_checks++;
            if (r_valid_w !== exp_rvalid || r_data_w !== exp_rdata_w) begin
                n_fail++;
                $display("FAIL rand_wrap[%0d]: got %0b/%h, required %0b/%h",
                         i, r_valid_w, r_data_w, exp_rvalid, exp_rdata_w);
            end
            n_checks++;
            if (acc_ovf_s !== ovf_s || acc_ovf_w !== ovf_w || busy_s !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: ovf %0b %0b busy %0b, required %0b %0b 0",
                         i, acc_ovf_s, acc_ovf_w, busy_s, ovf_s, ovf_w);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 9'd0, 1'b1, 1'b0, 9'd3, 16'h7000, 1'b0);
        step(1'b0, 9'd0, 1'b1, 1'b1, 9'd3, 16'h7000, 1'b0);
        step(1'b1, 9'd3, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_valid_s !== 1'b1 || r_data_s !== 16'h7FFF || acc_ovf_s !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_read: got %0b/%h/%0b, required 1/7fff/1", r_valid_s, r_data_s, acc_ovf_s);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({r_valid_s, r_data_s, busy_s, acc_ovf_s} !== 19'd0 || {r_valid_w, r_data_w, acc_ovf_w} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_mid_read: got %0b/%h/%0b/%0b, required all 0",
                     r_valid_s, r_data_s, busy_s, acc_ovf_s);
        end
        @(posedge clk); #1 reset = 1'b1;
        model_reset();
        step(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'd0, 1'b1);
        for (int i = 0; i < 100; i++) idle();
        n_checks++;
        if (busy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_sweep: got %0b, required 1", busy_s);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({r_valid_s, busy_s, acc_ovf_s, busy_w} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_sweep: valid=%0b busy=%0b ovf=%0b busy_w=%0b, required all 0",
                     r_valid_s, busy_s, acc_ovf_s, busy_w);
        end
        @(posedge clk); #1 reset = 1'b1;
        model_reset();
        step(1'b0, 9'd0, 1'b1, 1'b0, 9'd300, 16'h55AA, 1'b0);
        step(1'b1, 9'd300, 1'b1, 1'b1, 9'd300, 16'd1, 1'b0);
        n_checks++;
        if (r_valid_s !== 1'b1 || r_data_s !== 16'h55AA || busy_s !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_rw: got %0b/%h busy %0b, required 1/55aa busy 0", r_valid_s, r_data_s, busy_s);
        end
        step(1'b1, 9'd300, 1'b0, 1'b0, 9'd0, 16'd0, 1'b0);
        n_checks++;
        if (r_data_s !== 16'h55AB || r_data_w !== 16'h55AB) begin
            n_fail++;
            $display("FAIL post_reset_acc: got %h %h, required 55ab 55ab", r_data_s, r_data_w);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_accumulate();
        test_saturate();
        test_same_cycle();
        test_clear();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
